// File: rtl/secuenciador_texto.sv
// Text-overlay fetch scheduler: prefetches the font row of the next tile and serialises it to pixel_on.
// Latency: pixel_on one reloj cycle after the pixel's tick; font fetch takes 3 cycles. No backpressure.
module secuenciador_texto #(
    parameter int X0      = 50,
    parameter int Y0      = 16,
    parameter int N_CHARS = 16
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       tick,
    input  logic [9:0] Qh,
    input  logic [9:0] Qv,
    input  logic       video_on,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [1:0] wr_char,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pixel_on
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_buf [N_CHARS];
    logic [7:0] r_cur;
    logic [7:0] r_nxt;

    logic [7:0] w_tn;
    logic       w_row_hit;
    logic       w_tn_hit;
    logic [3:0] w_idx;
    logic [1:0] w_char;
    logic       w_prefetch;
    logic       w_load_addr;
    logic       w_capture;
    logic       w_wr_ok;
    logic [2:0] w_bitsel;

    // The tile after the current one; at Qh=796 this is 100, always outside the window.
    always_comb begin
        w_tn       = {1'b0, Qh[9:3]} + 8'd1;
        w_row_hit  = (Qv[9:4] == 6'(Y0));
        w_tn_hit   = w_row_hit && (w_tn >= 8'(X0)) && (w_tn < 8'(X0 + N_CHARS));
        w_idx      = 4'(w_tn - 8'(X0));
        w_char     = w_tn_hit ? r_buf[w_idx] : 2'd0;
        w_prefetch = tick && (Qh[2:0] == 3'b100);
        w_wr_ok    = wr_en && ({1'b0, wr_addr} < 5'(N_CHARS));
        w_bitsel   = 3'd7 - Qh[2:0];
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_addr = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_prefetch) begin
                    w_load_addr = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A write coinciding with the prefetch sample lands after the read, so that fetch sees the old code.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            for (int i = 0; i < N_CHARS; i++) begin
                r_buf[i] <= 2'd0;
            end
            rom_addr <= 6'd0;
            r_nxt    <= 8'd0;
            r_cur    <= 8'd0;
            pixel_on <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_buf[wr_addr] <= wr_char;
            end
            if (w_load_addr) begin
                rom_addr <= {w_char, Qv[3:0]};
            end
            if (w_capture) begin
                r_nxt <= rom_data;
            end
            if (tick) begin
                if (Qh[2:0] == 3'd0) begin
                    r_cur    <= r_nxt;
                    pixel_on <= r_nxt[7] & video_on;
                end else begin
                    pixel_on <= r_cur[w_bitsel] & video_on;
                end
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_texto.sv
// Bench for secuenciador_texto: line sweeps against a 1-cycle-latency font ROM model.
module tb_secuenciador_texto;

    localparam int X0      = 50;
    localparam int Y0      = 16;
    localparam int N_CHARS = 12;

    logic       reloj = 1'b0;
    logic       resetM;
    logic       tick;
    logic [9:0] Qh;
    logic [9:0] Qv;
    logic       video_on;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [1:0] wr_char;
    logic [5:0] rom_addr;
    logic [7:0] rom_data = 8'd0;
    logic       pixel_on;

    int n_chk = 0;
    int n_err = 0;

    logic       pix [0:799];
    logic [5:0] adr [0:799];

    secuenciador_texto #(.X0(X0), .Y0(Y0), .N_CHARS(N_CHARS)) dut (
        .reloj    (reloj),
        .resetM   (resetM),
        .tick     (tick),
        .Qh       (Qh),
        .Qv       (Qv),
        .video_on (video_on),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pixel_on (pixel_on)
    );

    always #5 reloj = ~reloj;

    // Font model: 'D' row 4 = 01100110, 'J' row 4 = 00001100, other rows distinct fillers.
    function automatic logic [7:0] font(input logic [5:0] a);
        logic [7:0] b;
        case (a[5:4])
            2'd1:    b = (a[3:0] == 4'd4) ? 8'h66 : 8'hF0;
            2'd2:    b = (a[3:0] == 4'd4) ? 8'h0C : 8'h0F;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always @(posedge reloj) rom_data <= font(rom_addr);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        @(posedge reloj); #1;
        wr_en = 1'b0;
    endtask

    // One tick per pixel, gap idle cycles after each; optional write of slot 0 <= 2 at coll_qh.
    task automatic sweep(input int qa, input int qb, input logic [9:0] qv, input logic vo,
                         input int gap, input int coll_qh);
        for (int q = qa; q <= qb; q++) begin
            Qh = 10'(q); Qv = qv; video_on = vo; tick = 1'b1;
            if (q == coll_qh) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_char = 2'd2;
            end
            @(posedge reloj); #1;
            tick = 1'b0; wr_en = 1'b0;
            pix[q] = pixel_on;
            adr[q] = rom_addr;
            for (int g = 0; g < gap; g++) begin
                @(posedge reloj); #1;
                chk("hold_between_ticks", {7'd0, pixel_on}, {7'd0, pix[q]});
            end
        end
    endtask

    function automatic logic [7:0] pbyte(input int q);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = pix[q+i];
        return b;
    endfunction

    typedef struct {
        int         gap;
        logic [9:0] qv;
        logic       vo;
        logic [5:0] exp_addr;
        logic [7:0] exp_t50;
        logic [7:0] exp_t51;
    } line_t;

    line_t tbl [5];

    initial begin
        tbl[0] = '{0, 10'd260, 1'b1, 6'h14, 8'h66, 8'h0C};
        tbl[1] = '{3, 10'd260, 1'b1, 6'h14, 8'h66, 8'h0C};
        tbl[2] = '{0, 10'd276, 1'b1, 6'h04, 8'h00, 8'h00};
        tbl[3] = '{0, 10'd260, 1'b0, 6'h14, 8'h00, 8'h00};
        tbl[4] = '{1, 10'd263, 1'b1, 6'h17, 8'hF0, 8'h0F};

        resetM = 1'b1; tick = 1'b1; Qh = 10'd300; Qv = 10'd260; video_on = 1'b1;
        wr_en = 1'b0; wr_addr = 4'd0; wr_char = 2'd0;
        @(posedge reloj); #1;
        Qh = 10'd301;
        @(posedge reloj); #1;
        resetM = 1'b0; tick = 1'b0;
        chk("reset_rom_addr", {2'd0, rom_addr}, 8'h00);
        chk("reset_pixel_on", {7'd0, pixel_on}, 8'h00);

        sweep(388, 415, 10'd260, 1'b1, 0, -1);
        chk("reset_sweep_t50", pbyte(400), 8'h00);
        chk("reset_sweep_t51", pbyte(408), 8'h00);

        // Reset in the middle of a fetch: the captured byte must not survive.
        wr(4'd0, 2'd1);
        sweep(388, 396, 10'd260, 1'b1, 0, -1);
        chk("midfetch_rom_addr", {2'd0, adr[396]}, 8'h14);
        resetM = 1'b1; tick = 1'b1; Qh = 10'd397;
        @(posedge reloj); #1;
        Qh = 10'd398;
        @(posedge reloj); #1;
        resetM = 1'b0; tick = 1'b0;
        chk("midfetch_reset_addr", {2'd0, rom_addr}, 8'h00);
        chk("midfetch_reset_px", {7'd0, pixel_on}, 8'h00);
        sweep(399, 415, 10'd260, 1'b1, 0, -1);
        chk("midfetch_t50_dark", pbyte(400), 8'h00);
        chk("midfetch_t51_dark", pbyte(408), 8'h00);

        wr(4'd0, 2'd1);
        wr(4'd1, 2'd2);
        wr(4'd11, 2'd1);
        for (int a = N_CHARS; a < 16; a++) wr(4'(a), 2'd2);

        for (int k = 0; k < 5; k++) begin
            sweep(388, 415, tbl[k].qv, tbl[k].vo, tbl[k].gap, -1);
            chk($sformatf("v%0d_rom_addr", k), {2'd0, adr[396]}, {2'd0, tbl[k].exp_addr});
            chk($sformatf("v%0d_t49", k), pbyte(392), 8'h00);
            chk($sformatf("v%0d_t50", k), pbyte(400), tbl[k].exp_t50);
            chk($sformatf("v%0d_t51", k), pbyte(408), tbl[k].exp_t51);
        end

        // Last slot of the window, then the first tile past it.
        sweep(484, 503, 10'd260, 1'b1, 0, -1);
        chk("edge_t61", pbyte(488), 8'h66);
        chk("edge_rom_addr_t62", {2'd0, adr[492]}, 8'h04);
        chk("edge_t62", pbyte(496), 8'h00);

        // Collision: write on the sample cycle; this line keeps 'D', the next shows 'J'.
        sweep(388, 415, 10'd264, 1'b1, 0, 396);
        chk("coll_rom_addr", {2'd0, adr[396]}, 8'h18);
        chk("coll_line_old", pbyte(400), 8'hF0);
        sweep(388, 415, 10'd265, 1'b1, 0, -1);
        chk("coll_next_addr", {2'd0, adr[396]}, 8'h29);
        chk("coll_line_new", pbyte(400), 8'h0F);
        chk("coll_slot1", pbyte(408), 8'h0F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
